// File: rtl/capture_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : capture_controller_if
//  Description : Host command bus and sample-buffer write port of the
//                logic-analyzer capture controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface capture_controller_if #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  cmd_recieved;
    logic [7:0]            opcode;
    logic [31:0]           command;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CHANNELS-1:0]   wr_data;
    logic                  capture_done;
    logic [1:0]            status;

    // Host / readout side
    modport master (
        output cmd_recieved, opcode, command,
        input  wr_en, wr_addr, wr_data, capture_done, status
    );

    // Controller side
    modport slave (
        input  cmd_recieved, opcode, command,
        output wr_en, wr_addr, wr_data, capture_done, status
    );
endinterface
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// ============================================================================
//  Module      : capture_controller
//  Description : Arms on host command, waits for a masked trigger on the
//                probes and streams divided-rate samples into the buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_controller #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic [CHANNELS-1:0] probe,
    capture_controller_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_CAPTURING = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [7:0] c_OP_ABORT     = 8'h00;
    localparam logic [7:0] c_OP_ARM       = 8'h01;
    localparam logic [7:0] c_OP_SET_DIV   = 8'h80;
    localparam logic [7:0] c_OP_SET_TRIG  = 8'h81;
    localparam logic [7:0] c_OP_SET_COUNT = 8'h82;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [23:0]           r_divider;
    logic [CHANNELS-1:0]   r_mask;
    logic [CHANNELS-1:0]   r_value;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [23:0]           r_div_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [CHANNELS-1:0]   r_wr_data;
    logic                  r_done;

    logic w_cmd_abort, w_cmd_arm, w_cmd_div, w_cmd_trig, w_cmd_count;
    logic w_cfg_ok, w_active, w_tick, w_match, w_write, w_last, w_enter_armed;
    logic w_unused_cmd;

    assign w_cmd_abort = bus.cmd_recieved && (bus.opcode == c_OP_ABORT);
    assign w_cmd_arm   = bus.cmd_recieved && (bus.opcode == c_OP_ARM);
    assign w_cmd_div   = bus.cmd_recieved && (bus.opcode == c_OP_SET_DIV);
    assign w_cmd_trig  = bus.cmd_recieved && (bus.opcode == c_OP_SET_TRIG);
    assign w_cmd_count = bus.cmd_recieved && (bus.opcode == c_OP_SET_COUNT);

    // Configuration is frozen while a capture is in flight
    assign w_cfg_ok = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_active = (r_state == S_ARMED) || (r_state == S_CAPTURING);
    assign w_tick   = w_active && (r_div_cnt == r_divider);
    assign w_match  = ((probe ^ r_value) & r_mask) == '0;

    assign w_enter_armed = (r_state != S_ARMED) && (w_state_nxt == S_ARMED);
    assign w_unused_cmd  = ^bus.command[31:24];

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_cmd_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick && w_match) begin
                    w_write = 1'b1;
                    if (r_count == '0) begin
                        w_state_nxt = S_DONE;
                        w_last      = 1'b1;
                    end else begin
                        w_state_nxt = S_CAPTURING;
                    end
                end
            end
            S_CAPTURING: begin
                if (w_cmd_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_write = 1'b1;
                    if (r_idx == r_count) begin
                        w_state_nxt = S_DONE;
                        w_last      = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (w_cmd_arm)        w_state_nxt = S_ARMED;
                else if (w_cmd_abort) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_divider <= '0;
            r_mask    <= '0;
            r_value   <= '0;
            r_count   <= '1;
            r_div_cnt <= '0;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_cfg_ok && w_cmd_div)   r_divider <= bus.command[23:0];
            if (w_cfg_ok && w_cmd_trig) begin
                r_mask  <= bus.command[16+CHANNELS-1:16];
                r_value <= bus.command[CHANNELS-1:0];
            end
            if (w_cfg_ok && w_cmd_count) r_count <= bus.command[ADDR_WIDTH-1:0];

            if (w_enter_armed)  r_div_cnt <= '0;
            else if (w_active)  r_div_cnt <= w_tick ? 24'd0 : r_div_cnt + 24'd1;

            // Index stops at the final sample so it never wraps
            if (w_enter_armed)           r_idx <= '0;
            else if (w_write && !w_last) r_idx <= r_idx + 1'b1;

            r_wr_en <= w_write;
            r_done  <= w_last;
            if (w_write) begin
                r_wr_addr <= r_idx;
                r_wr_data <= probe;
            end
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.capture_done = r_done;
    assign bus.status       = r_state;
endmodule
`default_nettype wire
